// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
// Owns the architectural PC and keeps at most one request outstanding to
// instruction memory. The returned word is buffered and offered downstream
// over a valid/ready handshake. Redirects from the next-PC logic can kill a
// buffered instruction or an in-flight fetch. A fetch that is still
// outstanding when a redirect arrives is drained: the request is held until
// the ack, its data is thrown away, and then the latest target is loaded.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] PC,
    input  logic [31:0] NPC,
    input  logic        npc_redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_OUT = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_r;
    logic        req_r;
    logic        valid_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;

    // Word-align a target address; the two low bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Fetch control FSM. Every output comes straight from a register.
    // The PC is not changed while draining, so the address of the
    // outstanding request stays on imem_addr until its ack arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            pending_r <= 32'h0000_0000;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            inst_r    <= 32'h0000_0000;
            inst_pc_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    // A redirect is ignored here. Fetching starts at RESET_PC.
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                end

                FETCH: begin
                    if (imem_ack) begin
                        if (npc_redirect) begin
                            // The returned word is on the wrong path. Drop it
                            // and issue a new request at the target.
                            pc_r <= align_pc(NPC);
                        end else begin
                            inst_r    <= imem_rdata;
                            inst_pc_r <= pc_r;
                            valid_r   <= 1'b1;
                            req_r     <= 1'b0;
                            state_r   <= WAIT_OUT;
                        end
                    end else if (npc_redirect) begin
                        // A request is never withdrawn. Remember the target
                        // and drain the outstanding fetch first.
                        pending_r <= align_pc(NPC);
                        state_r   <= DRAIN;
                    end else begin
                        state_r <= FETCH;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        // If a redirect arrives together with the ack, that
                        // newer target takes priority.
                        pc_r    <= npc_redirect ? align_pc(NPC) : pending_r;
                        state_r <= FETCH;
                    end else if (npc_redirect) begin
                        pending_r <= align_pc(NPC);
                    end else begin
                        state_r <= DRAIN;
                    end
                end

                WAIT_OUT: begin
                    if (inst_ready) begin
                        // The PC update wraps modulo 2^32.
                        pc_r    <= npc_redirect ? align_pc(NPC) : (pc_r + 32'd4);
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= FETCH;
                    end else if (npc_redirect) begin
                        // Kill the buffered instruction. It was never accepted.
                        pc_r    <= align_pc(NPC);
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= FETCH;
                    end else begin
                        state_r <= WAIT_OUT;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign PC         = pc_r;
    assign imem_addr  = pc_r;
    assign imem_req   = req_r;
    assign inst_valid = valid_r;
    assign inst_out   = inst_r;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit (RESET_PC = 0).
// Each row gives the inputs for one clock edge and the outputs expected
// just after that edge. inst_out and inst_pc are compared only on rows
// where inst_valid is expected to be high.
module tb_if_fetch_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        npc_redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    int checks;
    int failures;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_out;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .PC           (PC),
        .NPC          (NPC),
        .npc_redirect (npc_redirect),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] npc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_out, input logic [31:0] e_ipc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.npc = npc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_out = e_out; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        NPC = 32'h0;
        npc_redirect = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;

        //   ack  rdata          rdy  rdr  npc            req  addr           vld  out            ipc
        // Sequential fetch with zero-wait memory.
        add(1'b0, 32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h0000_0000,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h1111_0000, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0000,1'b1,32'h1111_0000, 32'h0000_0000);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_0004,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h1111_0004, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0004,1'b1,32'h1111_0004, 32'h0000_0004);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_0008,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h1111_0008, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0008,1'b1,32'h1111_0008, 32'h0000_0008);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_000C,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h1111_000C, 1'b0,1'b0,32'h0,         1'b0,32'h0000_000C,1'b1,32'h1111_000C, 32'h0000_000C);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_0010,1'b0,32'h0,         32'h0);
        // Ack delayed by three cycles: the request at 0x10 is held.
        add(1'b0, 32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h0000_0010,1'b0,32'h0,         32'h0);
        add(1'b0, 32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h0000_0010,1'b0,32'h0,         32'h0);
        add(1'b0, 32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h0000_0010,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h2222_0010, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0010,1'b1,32'h2222_0010, 32'h0000_0010);
        // Accept with a redirect whose low bits must be ignored (0x23 -> 0x20).
        add(1'b0, 32'h0,         1'b1,1'b1,32'h0000_0023, 1'b1,32'h0000_0020,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h3333_0020, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0020,1'b1,32'h3333_0020, 32'h0000_0020);
        // Accept 0x20 together with a redirect to 0x100.
        add(1'b0, 32'h0,         1'b1,1'b1,32'h0000_0100, 1'b1,32'h0000_0100,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h4444_0100, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0100,1'b1,32'h4444_0100, 32'h0000_0100);
        add(1'b0, 32'h0,         1'b1,1'b1,32'h0000_0040, 1'b1,32'h0000_0040,1'b0,32'h0,         32'h0);
        // Redirect to 0x200 while the fetch of 0x40 is outstanding: drain it.
        add(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0200, 1'b1,32'h0000_0040,1'b0,32'h0,         32'h0);
        add(1'b0, 32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h0000_0040,1'b0,32'h0,         32'h0);
        add(1'b1, 32'hDEAD_0040, 1'b0,1'b0,32'h0,         1'b1,32'h0000_0200,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h5555_0200, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0200,1'b1,32'h5555_0200, 32'h0000_0200);
        // Five stall cycles: the buffered instruction is held unchanged.
        for (int i = 0; i < 5; i++)
            add(1'b0, 32'h0,     1'b0,1'b0,32'h0,         1'b0,32'h0000_0200,1'b1,32'h5555_0200, 32'h0000_0200);
        // Redirect while stalled kills the buffered word.
        add(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0300, 1'b1,32'h0000_0300,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h6666_0300, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0300,1'b1,32'h6666_0300, 32'h0000_0300);
        // Move to the top of the address space (0xFFFFFFFF aligns to 0xFFFFFFFC), then wrap.
        add(1'b0, 32'h0,         1'b1,1'b1,32'hFFFF_FFFF, 1'b1,32'hFFFF_FFFC,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h7777_FFFC, 1'b0,1'b0,32'h0,         1'b0,32'hFFFF_FFFC,1'b1,32'h7777_FFFC, 32'hFFFF_FFFC);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_0000,1'b0,32'h0,         32'h0);
        // An ack arriving with a redirect discards the data and refetches at the target.
        add(1'b1, 32'hBAD0_0000, 1'b0,1'b1,32'h0000_0400, 1'b1,32'h0000_0400,1'b0,32'h0,         32'h0);
        add(1'b1, 32'h8888_0400, 1'b0,1'b0,32'h0,         1'b0,32'h0000_0400,1'b1,32'h8888_0400, 32'h0000_0400);
        add(1'b0, 32'h0,         1'b1,1'b0,32'h0,         1'b1,32'h0000_0404,1'b0,32'h0,         32'h0);
        // While draining, the latest redirect wins, including one that arrives with the ack.
        add(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0500, 1'b1,32'h0000_0404,1'b0,32'h0,         32'h0);
        add(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0600, 1'b1,32'h0000_0404,1'b0,32'h0,         32'h0);
        add(1'b1, 32'hDEAD_0404, 1'b0,1'b1,32'h0000_0700, 1'b1,32'h0000_0700,1'b0,32'h0,         32'h0);
        // Re-enter DRAIN so that the reset can be applied mid-drain.
        add(1'b0, 32'h0,         1'b0,1'b1,32'h0000_0800, 1'b1,32'h0000_0700,1'b0,32'h0,         32'h0);

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc",    PC,                  32'h0);
        chk("rst_out",   inst_out,            32'h0);
        chk("rst_ipc",   inst_pc,             32'h0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            imem_ack     = vecs[i].ack;
            imem_rdata   = vecs[i].rdata;
            inst_ready   = vecs[i].ready;
            npc_redirect = vecs[i].redir;
            NPC          = vecs[i].npc;
            @(posedge clk); #1;
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].e_addr);
            chk($sformatf("v%0d_pc", i),    PC,                  vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_out", i), inst_out, vecs[i].e_out);
                chk($sformatf("v%0d_ipc", i), inst_pc,  vecs[i].e_ipc);
            end
        end

        // Asynchronous reset in the middle of DRAIN takes effect without a clock edge.
        imem_ack = 1'b0;
        npc_redirect = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},   32'd0);
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_pc",    PC,                  32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        // A redirect seen in IDLE is ignored, so the first fetch is at RESET_PC.
        npc_redirect = 1'b1;
        NPC = 32'h0000_0900;
        @(posedge clk); #1;
        chk("idle_req",  {31'd0, imem_req}, 32'd1);
        chk("idle_addr", imem_addr,         32'h0);
        npc_redirect = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h9999_0000;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("post_valid", {31'd0, inst_valid}, 32'd1);
        chk("post_out",   inst_out,            32'h9999_0000);
        chk("post_ipc",   inst_pc,             32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
